// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op and state encodings,
// width constants and small op-class helpers.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    function automatic logic is_load(op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit.
// lsu_req_if: CPU request/response (master = CPU, slave = LSU).
// lsu_mem_if: word memory bus (master = LSU, slave = memory).
interface lsu_req_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              Req;
    logic [2:0]        Op;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic              Ready;
    logic              Done;
    logic [DATA_W-1:0] RData;
    logic              AlignErr;

    modport master (
        output Req, Op, Addr, WData,
        input  Ready, Done, RData, AlignErr
    );

    modport slave (
        input  Req, Op, Addr, WData,
        output Ready, Done, RData, AlignErr
    );
endinterface

interface lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemDataIn;
    logic [DATA_W-1:0] MemDataOut;
    logic              MemRead;
    logic              MemWrite;

    modport master (
        output MemAddress, MemDataIn, MemRead, MemWrite,
        input  MemDataOut
    );

    modport slave (
        input  MemAddress, MemDataIn, MemRead, MemWrite,
        output MemDataOut
    );
endinterface

// File: rtl/lsu_lane.sv
// Combinational big-endian lane logic: extract/extend for loads and
// lane merge for sub-word stores. Ports: op, lane, word, wdata in;
// load_data, merged out. Byte lane k sits at bits [31-8k -: 8].
module lsu_lane
    import lsu_pkg::*;
(
    input  op_e               op,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[31:24];
        unique case (lane)
            2'd0: byte_v = word[31:24];
            2'd1: byte_v = word[23:16];
            2'd2: byte_v = word[15:8];
            2'd3: byte_v = word[7:0];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_data = word;
        unique case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'd0, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_data = {16'd0, half_v};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        unique case (op)
            OP_SB: begin
                unique case (lane)
                    2'd0: merged = {wdata[7:0], word[23:0]};
                    2'd1: merged = {word[31:24], wdata[7:0], word[15:0]};
                    2'd2: merged = {word[31:16], wdata[7:0], word[7:0]};
                    2'd3: merged = {word[31:8], wdata[7:0]};
                    default: merged = word;
                endcase
            end
            OP_SH: begin
                if (lane[1])
                    merged = {word[31:16], wdata[15:0]};
                else
                    merged = {wdata[15:0], word[15:0]};
            end
            OP_SW:   merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-wide data memory.
// Ports: Clk, Reset (async, active-high); req (lsu_req_if.slave):
// Req/Op/Addr/WData in, Ready/Done/RData/AlignErr out; mem
// (lsu_mem_if.master): MemAddress/MemDataIn/MemRead/MemWrite out,
// MemDataOut in. Sub-word stores are read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned requests skip memory
// and complete with AlignErr; otherwise low address bits are ignored.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
)(
    input  logic      Clk,
    input  logic      Reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_RD_LAT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    op_e               op_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;
    op_e               req_op;
    logic              accept;
    logic              rd_last;
    logic              misalign;

    assign req_op  = op_e'(req.Op);
    assign accept  = req.Req && (state_q == S_IDLE);
    assign rd_last = (state_q == S_RD) && (cnt_q == RD_LAST);

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q;

    always_comb begin
        misalign = 1'b0;
        unique case (req_op)
            OP_LH, OP_LHU, OP_SH: misalign = req.Addr[0];
            OP_LW, OP_SW:         misalign = |req.Addr[1:0];
            default:              misalign = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            err_q <= 1'b0;
        else if (accept)
            err_q <= misalign;
    end

    assign req.AlignErr = (state_q == S_RESP) && err_q;
`else
    assign misalign     = 1'b0;
    assign req.AlignErr = 1'b0;
`endif

    lsu_lane u_lane (
        .op        (op_q),
        .lane      (lane_q),
        .word      (mem.MemDataOut),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req.Ready    = 1'b0;
        req.Done     = 1'b0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req.Ready = 1'b1;
                if (req.Req) begin
                    if (misalign)
                        state_d = S_RESP;
                    else if (req_op == OP_SW)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                mem.MemRead = 1'b1;
                if (rd_last)
                    state_d = is_load(op_q) ? S_RESP : S_WR;
            end
            S_WR: begin
                mem.MemWrite = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                req.Done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and write data are only touched at accept and at the
    // final read edge, so they stay stable across RD and WR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= '0;
            op_q    <= OP_LB;
            lane_q  <= 2'd0;
            wdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                lane_q  <= req.Addr[1:0];
                wdata_q <= req.WData;
                cnt_q   <= '0;
                if (!misalign) begin
                    addr_q <= {req.Addr[ADDR_W-1:2], 2'b00};
                    if (req_op == OP_SW)
                        data_q <= req.WData;
                end
            end
            if (state_q == S_RD) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (rd_last) begin
                    if (is_load(op_q))
                        rdata_q <= lane_load;
                    else
                        data_q <= lane_merged;
                end
            end
        end
    end

    assign mem.MemAddress = addr_q;
    assign mem.MemDataIn  = data_q;
    assign req.RData      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (read latency 1
// and 3), each with its own word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [1:0]  req_v = 2'b00;
    logic [2:0]  op_s = 3'd0;
    logic [31:0] addr_s = 32'd0;
    logic [31:0] wdata_s = 32'd0;

    lsu_req_if #(.ADDR_W(32)) r0 ();
    lsu_req_if #(.ADDR_W(32)) r1 ();
    lsu_mem_if #(.ADDR_W(32)) m0 ();
    lsu_mem_if #(.ADDR_W(32)) m1 ();

    assign r0.Req = req_v[0];
    assign r0.Op = op_s;
    assign r0.Addr = addr_s;
    assign r0.WData = wdata_s;
    assign r1.Req = req_v[1];
    assign r1.Op = op_s;
    assign r1.Addr = addr_s;
    assign r1.WData = wdata_s;

    load_store_unit #(.MEM_RD_LAT(1), .ADDR_W(32)) dut0 (
        .Clk(Clk), .Reset(Reset), .req(r0.slave), .mem(m0.master)
    );
    load_store_unit #(.MEM_RD_LAT(3), .ADDR_W(32)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(r1.slave), .mem(m1.master)
    );

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'd0;
            mem1[i] = 32'd0;
        end
    end

    assign m0.MemDataOut = mem0[m0.MemAddress[9:2]];
    assign m1.MemDataOut = mem1[m1.MemAddress[9:2]];

    always @(posedge Clk) begin
        if (m0.MemWrite) mem0[m0.MemAddress[9:2]] <= m0.MemDataIn;
        if (m1.MemWrite) mem1[m1.MemAddress[9:2]] <= m1.MemDataIn;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;
    int rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0, both = 0;
    logic [31:0] wa0 = 32'd0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (m0.MemRead) rd0++;
        if (m0.MemWrite) begin
            wr0++;
            wa0 = m0.MemAddress;
        end
        if (m1.MemRead) rd1++;
        if (m1.MemWrite) wr1++;
        if ((m0.MemRead && m0.MemWrite) || (m1.MemRead && m1.MemWrite))
            both++;
    end

    always @(negedge Clk) begin
        if (r0.Done) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("rdata0", r0.RData, e0.rdata);
                chk("alignerr0", {31'd0, r0.AlignErr}, {31'd0, e0.err});
                chk("latency0", 32'(cyc + 1 - e0.acc), 32'(e0.lat));
            end
        end
        if (r1.Done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rdata1", r1.RData, e1.rdata);
                chk("alignerr1", {31'd0, r1.AlignErr}, {31'd0, e1.err});
                chk("latency1", 32'(cyc + 1 - e1.acc), 32'(e1.lat));
            end
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? r0.Ready : r1.Ready;
    endfunction

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Issue one request; when hold is set Req stays high for lat cycles
    // after accept and any Ready seen meanwhile is counted in busy.
    task automatic issue(input int d, input op_e op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat,
                         input bit hold, output int busy);
        int t;
        exp_t e;
        busy = 0;
        t = 0;
        @(negedge Clk);
        while (!rdy(d) && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 20) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        op_s = op;
        addr_s = a;
        wdata_s = wd;
        req_v[d] = 1'b1;
        @(posedge Clk);
        #1;
        e.rdata = exp_rd;
        e.err = exp_err;
        e.lat = lat;
        e.acc = cyc;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        if (hold) begin
            repeat (lat) begin
                @(negedge Clk);
                if (rdy(d)) busy++;
            end
        end
        req_v[d] = 1'b0;
        t = 0;
        while (qsz(d) != 0 && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 50) chk("done_timeout", 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    logic [31:0] last0 = 32'd0;
    logic [31:0] last1 = 32'd0;
    int busy;
    int rs, ws;

    initial begin
        #1;
        chk("rst_flags", {27'd0, r0.Ready, r0.Done, r0.AlignErr,
                          m0.MemRead, m0.MemWrite}, 32'h10);
        chk("rst_rdata", r0.RData, 32'd0);
        chk("rst_addr", m0.MemAddress, 32'd0);
        chk("rst_din", m0.MemDataIn, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        ws = wr0;
        issue(0, OP_SW, 32'd200, 32'h11223344, last0, 1'b0, 2, 1'b0, busy);
        chk("sw_wr_cycles", 32'(wr0 - ws), 32'd1);
        chk("sw_wr_addr", wa0, 32'd200);
        chk("sw_word", mem0[50], 32'h11223344);

        last0 = 32'h11223344;
        issue(0, OP_LW, 32'd200, 32'd0, last0, 1'b0, 2, 1'b0, busy);

        rs = rd0;
        ws = wr0;
        issue(0, OP_SH, 32'd202, 32'hABCDBEEF, last0, 1'b0, 3, 1'b0, busy);
        chk("sh_rd_cycles", 32'(rd0 - rs), 32'd1);
        chk("sh_wr_cycles", 32'(wr0 - ws), 32'd1);
        chk("sh_word", mem0[50], 32'h1122BEEF);

        last0 = 32'hFFFFBEEF;
        issue(0, OP_LH, 32'd202, 32'd0, last0, 1'b0, 2, 1'b0, busy);

        issue(0, OP_SW, 32'd200, 32'h80FF7F01, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'hFFFFFF80;
        issue(0, OP_LB, 32'd200, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'hFFFFFFFF;
        issue(0, OP_LB, 32'd201, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'h0000007F;
        issue(0, OP_LB, 32'd202, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'h00000001;
        issue(0, OP_LB, 32'd203, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'h000000FF;
        issue(0, OP_LBU, 32'd201, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        last0 = 32'h000080FF;
        issue(0, OP_LHU, 32'd200, 32'd0, last0, 1'b0, 2, 1'b0, busy);

        issue(0, OP_SB, 32'd203, 32'h00000055, last0, 1'b0, 3, 1'b0, busy);
        chk("sb_word", mem0[50], 32'h80FF7F55);

        issue(0, OP_SW, 32'd204, 32'h01020304, last0, 1'b0, 2, 1'b0, busy);

        rs = rd0;
        ws = wr0;
`ifdef LSU_ALIGN_CHECK_EN
        issue(0, OP_LW, 32'd201, 32'd0, last0, 1'b1, 1, 1'b0, busy);
        chk("align_rd_cycles", 32'(rd0 - rs), 32'd0);
`else
        last0 = 32'h80FF7F55;
        issue(0, OP_LW, 32'd201, 32'd0, last0, 1'b0, 2, 1'b0, busy);
        chk("align_rd_cycles", 32'(rd0 - rs), 32'd1);
`endif
        chk("align_wr_cycles", 32'(wr0 - ws), 32'd0);

        ws = wr0;
        @(negedge Clk);
        op_s = OP_SB;
        addr_s = 32'd205;
        wdata_s = 32'h000000AA;
        req_v[0] = 1'b1;
        @(posedge Clk);
        #1;
        req_v[0] = 1'b0;
        chk("rst_mid_rd_active", {31'd0, m0.MemRead}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_mid_memread", {31'd0, m0.MemRead}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_mid_no_write", 32'(wr0 - ws), 32'd0);
        chk("rst_mid_word", mem0[51], 32'h01020304);
        chk("rst_mid_ready", {31'd0, r0.Ready}, 32'd1);
        chk("rst_mid_rdata", r0.RData, 32'd0);
        last0 = 32'd0;
        last1 = 32'd0;

        issue(1, OP_SW, 32'd200, 32'hCAFEF00D, last1, 1'b0, 2, 1'b0, busy);
        rs = rd1;
        last1 = 32'hCAFEF00D;
        issue(1, OP_LW, 32'd200, 32'd0, last1, 1'b0, 4, 1'b1, busy);
        chk("lat3_rd_cycles", 32'(rd1 - rs), 32'd3);
        chk("lat3_no_reaccept", 32'(busy), 32'd0);
        repeat (3) @(negedge Clk);
        chk("lat3_idle_ready", {31'd0, r1.Ready}, 32'd1);

        chk("rd_wr_overlap", 32'(both), 32'd0);
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
